// File: rtl/dec_16bit_timer.sv
// Loadable down-counting timer with prescaler, start/stop/busy/done handshake
// and optional auto-reload; next count comes from a full-adder ripple decrementer.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module dec_16bit_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Ripple decrement: count + all-ones with cin=0; final carry-out is discarded.
  logic [WIDTH-1:0] dec_value;
  logic [WIDTH:0]   carry;
  logic             dec_carry_unused;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    full_adder u_fa (
      .a    (count_q[i]),
      .b    (1'b1),
      .cin  (carry[i]),
      .sum  (dec_value[i]),
      .cout (carry[i+1])
    );
  end

  assign dec_carry_unused = carry[WIDTH];

  logic [WIDTH-1:0] eff_count;
  logic             tick;

  assign eff_count = load ? load_value : count_q;
  assign tick      = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      presc_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            presc_d = '0;
          end
        end
      end
      RUN: begin
        // A load this cycle pre-empts stop, expiry and the decrement.
        if (!load) begin
          if (stop) begin
            state_d = IDLE;
            presc_d = '0;
          end else if (count_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (tick) begin
            presc_d = '0;
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = dec_value;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_dec_16bit_timer.sv
// Self-checking bench: two timer instances (PRESCALE 1 and 3) on shared inputs,
// checked against a behavioural model, a vector table and directed sequences.

module tb_dec_16bit_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] load_value;
  logic        start, stop, auto_reload;
  logic [15:0] count1, count3;
  logic        busy1, busy3, done1, done3;

  always #5 clk = ~clk;

  dec_16bit_timer #(.WIDTH(16), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count1), .busy(busy1), .done(done1)
  );

  dec_16bit_timer #(.WIDTH(16), .PRESCALE(3)) u_p3 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count3), .busy(busy3), .done(done3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the PRESCALE=1 instance, index 1 PRESCALE=3.
  int m_ps[2] = '{1, 3};
  int m_cnt[2], m_rel[2], m_ph[2];
  bit m_run[2], m_done[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_ph[i] = 0; m_run[i] = 0; m_done[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit ld, input int lv, input bit st,
                                     input bit sp, input bit ar);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (ld) begin
        m_cnt[i] = lv & 16'hFFFF;
        m_rel[i] = lv & 16'hFFFF;
        m_ph[i]  = 0;
      end
      if (!m_run[i]) begin
        if (st) begin
          if (m_cnt[i] == 0) m_done[i] = 1;
          else begin m_run[i] = 1; m_ph[i] = 0; end
        end
      end else if (!ld) begin
        if (sp) begin
          m_run[i] = 0; m_ph[i] = 0;
        end else if (m_cnt[i] == 0) begin
          m_done[i] = 1; m_run[i] = 0;
        end else if (m_ph[i] + 1 == m_ps[i]) begin
          m_ph[i] = 0;
          if (m_cnt[i] == 1) begin
            m_done[i] = 1;
            if (ar) m_cnt[i] = m_rel[i];
            else begin m_cnt[i] = 0; m_run[i] = 0; end
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end else begin
          m_ph[i] = m_ph[i] + 1;
        end
      end
    end
  endfunction

  task automatic check_model();
    chk("m_p1_count", count1, m_cnt[0]);
    chk("m_p1_busy",  busy1,  m_run[0]);
    chk("m_p1_done",  done1,  m_done[0]);
    chk("m_p3_count", count3, m_cnt[1]);
    chk("m_p3_busy",  busy3,  m_run[1]);
    chk("m_p3_done",  done3,  m_done[1]);
  endtask

  task automatic tick(input bit ld, input int lv, input bit st, input bit sp, input bit ar);
    load = ld; load_value = lv[15:0]; start = st; stop = sp; auto_reload = ar;
    @(posedge clk);
    model_step(ld, lv, st, sp, ar);
    #1;
    check_model();
  endtask

  task automatic exp1(input string name, input int c, input bit b, input bit d);
    chk({name, "_p1_count"}, count1, c);
    chk({name, "_p1_busy"},  busy1,  b);
    chk({name, "_p1_done"},  done1,  d);
  endtask

  task automatic exp3(input string name, input int c, input bit b, input bit d);
    chk({name, "_p3_count"}, count3, c);
    chk({name, "_p3_busy"},  busy3,  b);
    chk({name, "_p3_done"},  done3,  d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit ld; int lv; bit st; bit sp; bit ar;
    int ec; bit eb; bit ed;
  } vec_t;

  vec_t tbl[8];
  int   seq_cnt[6] = '{2, 1, 3, 2, 1, 3};
  bit   seq_done[6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    // PRESCALE=1 countdown from 5; expected values are for the p1 instance.
    tbl[0] = '{1, 5, 0, 0, 0, 5, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 5, 1, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 4, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 3, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 2, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; load = 0; load_value = '0; start = 0; stop = 0; auto_reload = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp1("reset", 0, 0, 0);
    exp3("reset", 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].ar);
      exp1($sformatf("tbl%0d", i), tbl[i].ec, tbl[i].eb, tbl[i].ed);
    end

    // PRESCALE=3 countdown from 2, then start with count 0.
    do_reset();
    tick(1, 2, 0, 0, 0);
    tick(0, 0, 1, 0, 0);  exp3("ps3_start", 2, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);  exp3("ps3_e2", 2, 1, 0);
    tick(0, 0, 0, 0, 0);  exp3("ps3_e3", 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);  exp3("ps3_e6", 0, 0, 1);
    tick(0, 0, 1, 0, 0);  exp3("ps3_zero_start", 0, 0, 1);
    tick(0, 0, 0, 0, 0);  exp3("ps3_after", 0, 0, 0);

    // Auto-reload on p1: load 3, periodic expiries, then let it run out.
    do_reset();
    tick(1, 3, 0, 0, 1);
    tick(0, 0, 1, 0, 1);  exp1("ar_start", 3, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 1);
      exp1($sformatf("ar_seq%0d", i), seq_cnt[i], 1, seq_done[i]);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);  exp1("ar_off_end", 0, 0, 1);

    // Stop coincident with the expiry tick, then restart.
    do_reset();
    tick(1, 4, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);  exp1("stop_pre", 1, 1, 0);
    tick(0, 0, 0, 1, 0);  exp1("stop_hit", 1, 0, 0);
    tick(0, 0, 1, 0, 0);  exp1("stop_restart", 1, 1, 0);
    tick(0, 0, 0, 0, 0);  exp1("stop_expire", 0, 0, 1);

    // Loads during RUN, and load+start with all-ones.
    do_reset();
    tick(1, 16, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 16'h8000, 0, 0, 0);  exp3("ld_run", 16'h8000, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);         exp3("ld_run_p2", 16'h8000, 1, 0);
    tick(0, 0, 0, 0, 0);         exp3("ld_run_p3", 16'h7FFF, 1, 0);
    tick(1, 0, 0, 0, 0);         exp3("ld0_run", 0, 1, 0);
    tick(0, 0, 0, 0, 0);         exp3("ld0_expire", 0, 0, 1);
    tick(1, 16'hFFFF, 1, 0, 0);  exp3("ldst_ffff", 16'hFFFF, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);         exp3("ffff_dec", 16'hFFFE, 1, 0);
    exp1("ffff_dec", 16'hFFFC, 1, 0);

    // Asynchronous reset between edges while counting.
    tick(1, 100, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    exp1("async_rst", 0, 0, 0);
    exp3("async_rst", 0, 0, 0);
    model_reset();
    #1;
    rst = 1'b0;
    tick(0, 0, 1, 0, 0);  exp1("rst_zero_start", 0, 0, 1);
    exp3("rst_zero_start", 0, 0, 1);
    tick(0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) == 0), $urandom_range(0, 6),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_16bit_timer.md
Name: dec_16bit_timer

Overview:
Loadable down-counting timer, the decrement-direction counterpart of the 16-bit incrementer in the ALU library. The next-count value comes from a structural ripple-borrow decrementer, built from full_adder cells that add all-ones with cin=0. Control logic adds a prescaler, a start/stop/busy/done handshake and optional auto-reload. Intended as the countdown/delay unit beside the ALU datapath.

Parameters:
WIDTH, 16, counter and load-value width.
PRESCALE, 1, clock cycles per decrement tick (legal range >=1; prescaler width is clog2(PRESCALE), minimum 1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
load  input  1  capture load_value into count and reload register.
load_value  input  WIDTH  value captured on load.
start  input  1  begin countdown (honoured in IDLE only).
stop  input  1  abort countdown (honoured in RUN only).
auto_reload  input  1  on expiry, reload and keep running instead of stopping.
count  output  WIDTH  current counter value (registered).
busy  output  1  high while in RUN.
done  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset (async, any time incl. mid-count): state=IDLE; count=0; reload_reg=0; prescaler=0; busy=0; done=0.
- States: IDLE, RUN. busy = (state==RUN), registered.
- done defaults to 0 every cycle and is high for exactly one cycle per expiry.
- Decrement: next = count + {WIDTH{1'b1}} via ripple chain; the carry-out is discarded. Wrap 0->all-ones never occurs because zero is detected first.
- load (any state): count<=load_value, reload_reg<=load_value, prescaler<=0. State is unchanged. load overrides the decrement, expiry and stop in the same cycle.
- IDLE + start:
  - Compare against the effective count, which is load_value if load is also high this cycle.
  - Effective count == 0: done=1 next cycle, stay IDLE.
  - Otherwise: go to RUN with prescaler=0.
- start in RUN is ignored. stop in IDLE is ignored.
- RUN, per cycle, no load (first matching rule applies):
  1. stop: go to IDLE, count holds, prescaler<=0, no done. stop wins over a coincident tick or expiry.
  2. count==0 (reachable only via load 0 during RUN): done=1, go to IDLE.
  3. prescaler==PRESCALE-1 (a tick): prescaler<=0.
     - count==1 and auto_reload=0: count<=0, done=1, go to IDLE.
     - count==1 and auto_reload=1: count<=reload_reg, done=1, stay RUN.
     - Otherwise: count<=count-1.
  4. Otherwise: prescaler<=prescaler+1.
- Latency: start sampled at edge E with count=N>0.
  - First decrement at edge E+PRESCALE.
  - count=0, done=1 and busy=0 are all visible after edge E+N*PRESCALE.
  - With auto_reload, done pulses every N*PRESCALE cycles.
- auto_reload is sampled only at the expiry tick.
- A load during RUN restarts the prescaler phase.
- Maximum span: N=0xFFFF gives 65535*PRESCALE cycles.

Test Plan:
1. PRESCALE=1: load 5, then start next cycle → count 4,3,2,1,0 on successive edges. busy high for 5 cycles. done pulses once, coincident with count==0. Then IDLE.
2. PRESCALE=3: load 0x0002, start → count 0x0001 at edge+3, 0x0000 at edge+6, one done pulse. start with count=0 → done pulse next cycle, busy stays 0.
3. auto_reload=1: load 3, start → done pulses at edges +3, +6, +9 and count sequence 2,1,3,2,1,3. Deassert auto_reload → stops after the next expiry with count=0.
4. Start with count=4, assert stop when count==1 (same cycle as the expiry tick) → IDLE, count stays 1, no done. Restart with start → done one cycle later.
5. During RUN: load 0x8000 → count=0x8000, prescaler restarts, still busy. Load 0 during RUN → done next cycle, IDLE. load+start together in IDLE with load_value=0xFFFF → RUN, count decrements from 0xFFFF to 0xFFFE with no wrap.
6. Assert rst asynchronously mid-count (between clock edges) → count=0, busy=0, done=0 immediately. After rst is released, start with count=0 → done pulse only.
